cell_out_sched: RTL

CELL_OUT_SCHED -- requirements
Module: cell_out_sched

---
 rtl/cell_out_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cell_out_sched.sv
// Cell output scheduler: round-robin grant over four cell queues, streams one
// cell of CELL_BEATS 64-bit words per grant to a shared output data bus.
module cell_out_sched #(
   parameter int CELL_BEATS = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sched_en,
   input  logic [3:0]   q_req,
   input  logic [3:0]   q_first,
   input  logic [3:0]   q_last,
   input  logic [11:0]  q_pad_num,
   input  logic [255:0] q_dout,
   output logic [3:0]   q_rd,
   input  logic [3:0]   o_cell_bp,
   output logic [3:0]   o_vaild,
   output logic         o_cell_first,
   output logic         o_cell_last,
   output logic [2:0]   o_pad_num_64,
   output logic [63:0]  pktout_data,
   output logic [3:0]   pktout_data_wr,
   output logic         err_underrun
);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(CELL_BEATS - 1);

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  beat_q, beat_d;
   logic [1:0]  g_q, g_d;
   logic [1:0]  last_g_q, last_g_d;
   logic        err_q, err_d;

   logic [3:0]  elig_s;
   logic [1:0]  pick_s;
   logic        found_s;
   logic [3:0]  q_rd_s;

   logic [3:0]  vaild_q;
   logic        first_q;
   logic        last_q;
   logic [2:0]  pad_q;
   logic [63:0] data_q;
   logic [3:0]  wr_q;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      elig_s  = q_req & ~o_cell_bp;
      pick_s  = 2'd0;
      found_s = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found_s && elig_s[last_g_q + 2'(k)]) begin
            pick_s  = last_g_q + 2'(k);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      g_d      = g_q;
      last_g_d = last_g_q;
      err_d    = err_q;
      q_rd_s   = 4'b0000;
      case (state_q)
         IDLE: begin
            if (sched_en && found_s) begin
               g_d      = pick_s;
               last_g_d = pick_s;
               beat_d   = 4'd0;
               state_d  = XFER;
            end else begin
               state_d  = IDLE;
            end
         end
         XFER: begin
            // Pops continue even if the queue ran dry; the flag records it.
            q_rd_s = onehot4(g_q);
            if (!q_req[g_q]) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (beat_q == LAST_BEAT) begin
               beat_d  = 4'd0;
               state_d = IDLE;
            end else begin
               beat_d  = beat_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         beat_q   <= 4'd0;
         g_q      <= 2'd0;
         last_g_q <= 2'd3;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         g_q      <= g_d;
         last_g_q <= last_g_d;
         err_q    <= err_d;
      end
   end

   // Header is captured on the first beat so it lines up with the first data write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q  <= 64'd0;
         wr_q    <= 4'b0000;
         vaild_q <= 4'b0000;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         pad_q   <= 3'd0;
      end else begin
         data_q <= q_dout[{g_q, 6'b000000} +: 64];
         wr_q   <= q_rd_s;
         if (state_q == XFER && beat_q == 4'd0) begin
            vaild_q <= onehot4(g_q);
            first_q <= q_first[g_q];
            last_q  <= q_last[g_q];
            pad_q   <= q_pad_num[int'(g_q) * 3 +: 3];
         end else begin
            vaild_q <= 4'b0000;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pad_q   <= 3'd0;
         end
      end
   end

   assign q_rd           = q_rd_s;
   assign o_vaild        = vaild_q;
   assign o_cell_first   = first_q;
   assign o_cell_last    = last_q;
   assign o_pad_num_64   = pad_q;
   assign pktout_data    = data_q;
   assign pktout_data_wr = wr_q;
   assign err_underrun   = err_q;

endmodule
